mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS main control FSM; issues the aluop[1:0] code consumed by the ALU decoder
//  (00 add, 01 sub, 10 funct-decoded), plus all datapath mux selects and write enables.
//  Sits between the instruction register opcode field and the multicycle datapath.
//  Moore outputs decoded from the state register; only pcen also depends on ALU zero.
// PARAMETERS
//  OP_LW    6'b100011  load word opcode
//  OP_SW    6'b101011  store word opcode
//  OP_RTYPE 6'b000000  R-type opcode
//  OP_BEQ   6'b000100  branch-equal opcode
//  OP_ADDI  6'b001000  add-immediate opcode
//  OP_J     6'b000010  jump opcode
// PORTS
//  clk       in   1  clock, rising edge
//  reset     in   1  asynchronous, active-high
//  op        in   6  instruction opcode [31:26] from IR
//  zero      in   1  ALU zero flag
//  pcen      out  1  PC write enable = pcwrite | (branch & zero)
//  irwrite   out  1  IR write enable
//  memwrite  out  1  memory write enable
//  regwrite  out  1  register file write enable
//  iord      out  1  memory address: 0=PC, 1=ALUOut
//  memtoreg  out  1  RF write data: 0=ALUOut, 1=Data
//  regdst    out  1  RF write addr: 0=rt, 1=rd
//  alusrca   out  1  ALU A: 0=PC, 1=A
//  alusrcb   out  2  ALU B: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//  pcsrc     out  2  PC next: 00=ALUResult, 01=ALUOut, 10=PCJump
//  aluop     out  2  to ALU decoder
//  illegal   out  1  one-cycle pulse: unknown opcode seen in DECODE
//  state     out  4  current state encoding (debug)
// BEHAVIOUR
//  States: S0 FETCH, S1 DECODE, S2 MEMADR, S3 MEMRD, S4 MEMWB, S5 MEMWR, S6 EXECUTE,
//   S7 ALUWB, S8 BRANCH, S9 ADDIEX, S10 ADDIWB, S11 JUMP, S12 BNE (macro only); encode 0..12.
//  Transitions: S0->S1 always. S1: lw/sw->S2, R->S6, beq->S8, addi->S9, j->S11, else->S0.
//   S2: lw->S3, sw->S5. S3->S4. S6->S7. S9->S10. S4,S5,S7,S8,S10,S11,S12->S0.
//  Outputs (unlisted = 0; aluop 00, alusrcb 00, pcsrc 00):
//   S0 iord=0 alusrca=0 alusrcb=01 irwrite=1 pcwrite=1. S1 alusrcb=11.
//   S2 alusrca=1 alusrcb=10. S3 iord=1. S4 memtoreg=1 regwrite=1. S5 iord=1 memwrite=1.
//   S6 alusrca=1 aluop=10. S7 regdst=1 regwrite=1. S8 alusrca=1 aluop=01 pcsrc=01 branch=1.
//   S9 alusrca=1 alusrcb=10. S10 regwrite=1. S11 pcsrc=10 pcwrite=1.
//  Cycles per instr: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2 (S0,S1).
//  illegal=1 combinationally in S1 when op matches none; next state S0, no writes issued.
//  Reset: async, state<=S0 immediately; while reset=1 pcen, irwrite, memwrite, regwrite
//   forced 0, illegal=0; other outputs show S0 values. Reset mid-instruction aborts it;
//   first edge after deassert performs a normal FETCH.
//  Unused state codes (13..15): all outputs 0, next state S0.
//  zero sampled only via pcen (combinational); ignored outside S8/S12.
// CONFIGURATION
//  MC_CONTROLLER_BNE_EN defined: opcode 6'b000101 in S1 -> S12 BNE; S12 outputs as S8
//   but pcen = ~zero; 3 cycles. Undefined: 6'b000101 is illegal (pulse, back to S0),
//   S12 unreachable and treated as an unused code.
// TESTING
//  reset=1 mid-S3 -> state=0 same cycle, all write enables 0; release -> S0,S1 sequence.
//  op=100011 -> states 0,1,2,3,4,0; regwrite=1 memtoreg=1 only in S4; iord=1 in S3.
//  op=000000 -> 0,1,6,7,0; aluop=10 in S6; regwrite=1 regdst=1 in S7.
//  op=000100 zero=1 -> pcen=1 pcsrc=01 aluop=01 in S8; repeat zero=0 -> pcen=0.
//  op=111111 -> illegal=1 in S1 only, next state 0, no write enable asserted.
//  op=000101 zero=0 -> with macro: S12 pcen=1; without: illegal=1, back to S0.

Source files
------------

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//   Main control FSM for a multicycle MIPS datapath. Steps each instruction
//   through FETCH/DECODE and the opcode-specific execute states, driving the
//   datapath mux selects, write enables and the 2-bit aluop code for the ALU
//   decoder (00 add, 01 sub, 10 funct-decoded).
//
//   Optional feature: define MC_CONTROLLER_BNE_EN to add branch-not-equal
//   (opcode 000101, state 12). Without it that opcode decodes as illegal.
//
// Ports
//   clk       in   1  clock, rising edge
//   reset     in   1  asynchronous, active-high
//   op        in   6  instruction opcode [31:26] from IR
//   zero      in   1  ALU zero flag (only used through pcen)
//   pcen      out  1  PC write enable = pcwrite | (branch & zero)
//   irwrite   out  1  IR write enable
//   memwrite  out  1  memory write enable
//   regwrite  out  1  register file write enable
//   iord      out  1  memory address: 0=PC, 1=ALUOut
//   memtoreg  out  1  RF write data: 0=ALUOut, 1=Data
//   regdst    out  1  RF write addr: 0=rt, 1=rd
//   alusrca   out  1  ALU A: 0=PC, 1=A
//   alusrcb   out  2  ALU B: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//   pcsrc     out  2  PC next: 00=ALUResult, 01=ALUOut, 10=PCJump
//   aluop     out  2  to ALU decoder
//   illegal   out  1  high in DECODE when the opcode is not recognised
//   state     out  4  current state encoding (debug)
// -----------------------------------------------------------------------------
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  // Moore control word; pcwrite/branch/branch_ne combine with zero into pcen.
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   op_legal;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BRANCH:  begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1;
      end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
`ifdef MC_CONTROLLER_BNE_EN
      S_BNE:     begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch_ne = 1'b1;
      end
`endif
      default:   c = '0;  // unused codes drive nothing
    endcase
    return c;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] opc);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:   n = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_EXECUTE;
          OP_BEQ:       n = S_BRANCH;
          OP_ADDI:      n = S_ADDIEX;
          OP_J:         n = S_JUMP;
`ifdef MC_CONTROLLER_BNE_EN
          OP_BNE:       n = S_BNE;
`endif
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR:  n = (opc == OP_LW) ? S_MEMRD : (opc == OP_SW) ? S_MEMWR : S_FETCH;
      S_MEMRD:   n = S_MEMWB;
      S_EXECUTE: n = S_ALUWB;
      S_ADDIEX:  n = S_ADDIWB;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path
  // (here via the default first), otherwise synthesis infers a latch.
  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
`ifdef MC_CONTROLLER_BNE_EN
      OP_BNE: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_comb state_d = next_state(state_q, op);

  // The control word is registered from the next state so it always matches
  // state_q while coming straight from flops.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  // Write enables and illegal are masked while reset is held so a reset in
  // the middle of an instruction cannot commit anything.
  assign pcen     = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & zero) |
                              (ctrl_q.branch_ne & ~zero));
  assign irwrite  = ~reset & ctrl_q.irwrite;
  assign memwrite = ~reset & ctrl_q.memwrite;
  assign regwrite = ~reset & ctrl_q.regwrite;
  assign illegal  = ~reset & (state_q == S_DECODE) & ~op_legal;

  assign iord     = ctrl_q.iord;
  assign memtoreg = ctrl_q.memtoreg;
  assign regdst   = ctrl_q.regdst;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign aluop    = ctrl_q.aluop;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
//   Self-checking bench for mc_controller. For each instruction the expected
//   per-cycle state and output vector are pushed to a queue when the opcode is
//   driven, then popped and compared once per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       illegal;
  logic [3:0] state;

`ifdef MC_CONTROLLER_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  // {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,
  //  alusrcb,pcsrc,aluop,illegal}
  wire [14:0] obs = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
                     alusrca, alusrcb, pcsrc, aluop, illegal};

  typedef struct {
    logic [3:0]  st;
    logic [14:0] outs;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010) ||
           (BNE_EN && o == 6'b000101);
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [5:0] o);
    case (s)
      4'd0: return 4'd1;
      4'd1: begin
        if (o == 6'b100011 || o == 6'b101011) return 4'd2;
        if (o == 6'b000000) return 4'd6;
        if (o == 6'b000100) return 4'd8;
        if (o == 6'b001000) return 4'd9;
        if (o == 6'b000010) return 4'd11;
        if (BNE_EN && o == 6'b000101) return 4'd12;
        return 4'd0;
      end
      4'd2: return (o == 6'b100011) ? 4'd3 : 4'd5;
      4'd3: return 4'd4;
      4'd6: return 4'd7;
      4'd9: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [14:0] model_out(input logic [3:0] s, input logic [5:0] o,
                                            input logic z, input logic rst);
    logic pc_e, ir_w, mem_w, reg_w, i_d, m2r, r_d, a_a, ill;
    logic [1:0] a_b, p_s, a_op;
    {pc_e, ir_w, mem_w, reg_w, i_d, m2r, r_d, a_a, ill} = '0;
    {a_b, p_s, a_op} = '0;
    case (s)
      4'd0:  begin a_b = 2'b01; ir_w = 1'b1; pc_e = 1'b1; end
      4'd1:  begin a_b = 2'b11; ill = !is_legal(o); end
      4'd2:  begin a_a = 1'b1; a_b = 2'b10; end
      4'd3:  i_d = 1'b1;
      4'd4:  begin m2r = 1'b1; reg_w = 1'b1; end
      4'd5:  begin i_d = 1'b1; mem_w = 1'b1; end
      4'd6:  begin a_a = 1'b1; a_op = 2'b10; end
      4'd7:  begin r_d = 1'b1; reg_w = 1'b1; end
      4'd8:  begin a_a = 1'b1; a_op = 2'b01; p_s = 2'b01; pc_e = z; end
      4'd9:  begin a_a = 1'b1; a_b = 2'b10; end
      4'd10: reg_w = 1'b1;
      4'd11: begin p_s = 2'b10; pc_e = 1'b1; end
      4'd12: if (BNE_EN) begin a_a = 1'b1; a_op = 2'b01; p_s = 2'b01; pc_e = ~z; end
      default: ;
    endcase
    if (rst) {pc_e, ir_w, mem_w, reg_w, ill} = '0;
    return {pc_e, ir_w, mem_w, reg_w, i_d, m2r, r_d, a_a, a_b, p_s, a_op, ill};
  endfunction

  // Called on a falling edge with the DUT in FETCH; returns on a falling edge
  // with the DUT expected back in FETCH.
  task automatic run_instr(input string name, input logic [5:0] opc, input logic z);
    logic [3:0] s;
    int guard;
    op   = opc;
    zero = z;
    s = 4'd0;
    guard = 0;
    do begin
      exp_q.push_back('{st: s, outs: model_out(s, opc, z, 1'b0)});
      s = model_next(s, opc);
      guard++;
    end while (s != 4'd0 && guard < 16);
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({name, "_state"}, {28'd0, state}, {28'd0, e.st});
      check({name, "_outs"},  {17'd0, obs},   {17'd0, e.outs});
      @(posedge clk);
      @(negedge clk);
    end
    check({name, "_return_to_fetch"}, {28'd0, state}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    zero  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_outs",  {17'd0, obs},   {17'd0, model_out(4'd0, op, 1'b0, 1'b1)});
    reset = 1'b0;

    run_instr("lw",       6'b100011, 1'b0);
    run_instr("sw",       6'b101011, 1'b0);
    run_instr("rtype",    6'b000000, 1'b0);
    run_instr("beq_z1",   6'b000100, 1'b1);
    run_instr("beq_z0",   6'b000100, 1'b0);
    run_instr("addi",     6'b001000, 1'b1);
    run_instr("j",        6'b000010, 1'b0);
    run_instr("ill_3f",   6'b111111, 1'b1);
    run_instr("bne_z0",   6'b000101, 1'b0);
    run_instr("bne_z1",   6'b000101, 1'b1);

    // Abort a load in MEMRD with an asynchronous reset between edges.
    op = 6'b100011;
    zero = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_in_memrd", {28'd0, state}, 32'd3);
    #2 reset = 1'b1;
    #1;
    check("abort_state", {28'd0, state}, 32'd0);
    check("abort_outs",  {17'd0, obs},   {17'd0, model_out(4'd0, op, 1'b0, 1'b1)});
    @(negedge clk);
    check("held_reset_state", {28'd0, state}, 32'd0);
    reset = 1'b0;
    run_instr("lw_after_reset", 6'b100011, 1'b0);

    // Mixed opcodes, including arbitrary ones, with random zero.
    for (int i = 0; i < 24; i++) begin
      logic [5:0] o;
      case ($urandom_range(0, 7))
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b000100;
        4: o = 6'b001000;
        5: o = 6'b000010;
        6: o = 6'b000101;
        default: o = 6'($urandom_range(0, 63));
      endcase
      run_instr($sformatf("mix%0d_op%02h", i, o), o, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
